// File: rtl/rotating_square_pkg.sv
// Shared types and segment codes for the rotating square sequencer.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package rotating_square_pkg;

  typedef logic [2:0] pos_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_UPPER = 7'h1C;
  localparam seg_t SEG_LOWER = 7'h23;
  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/rotating_square_ctrl_tick_gen.sv
// tick_gen: enable-gated mod-DIV prescaler with synchronous clear.
// Ports: clk, rst (sync, high), en, clr in; tick out (en & cnt==DIV-1).
module tick_gen
  import rotating_square_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W =
    $clog2(DIV) > 0 ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en & (cnt == LAST);

  // Holding cnt while en is low keeps the
  // partial period intact across a freeze.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rotating_square_ctrl.sv
// Rotating square pattern sequencer for a 4-digit 7-seg multiplexer.
// Ports: clk_i, rst_i, en_i, cw_i, clr_i in; in0_o..in3_o, pos_o, step_o out.
module rotating_square_ctrl
  import rotating_square_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       cw_i,
  input  logic       clr_i,
  output logic [6:0] in0_o,
  output logic [6:0] in1_o,
  output logic [6:0] in2_o,
  output logic [6:0] in3_o,
  output logic [2:0] pos_o,
  output logic       step_o
);

  pos_t pos;
  logic step;
  logic tick;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk_i),
    .rst  (rst_i),
    .en   (en_i),
    .clr  (clr_i),
    .tick (tick)
  );

  // clr wins over a coincident tick.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos  <= '0;
      step <= 1'b0;
    end else if (clr_i) begin
      pos  <= '0;
      step <= 1'b0;
    end else begin
      step <= tick;
      if (tick) begin
        pos <= cw_i ? pos + 3'd1
                    : pos - 3'd1;
      end
    end
  end

  seg_t d0, d1, d2, d3;

  // Upper half sweeps left to right,
  // lower half returns right to left.
  always_comb begin
    d0 = SEG_BLANK;
    d1 = SEG_BLANK;
    d2 = SEG_BLANK;
    d3 = SEG_BLANK;
    unique case (pos)
      3'd0: d3 = SEG_UPPER;
      3'd1: d2 = SEG_UPPER;
      3'd2: d1 = SEG_UPPER;
      3'd3: d0 = SEG_UPPER;
      3'd4: d0 = SEG_LOWER;
      3'd5: d1 = SEG_LOWER;
      3'd6: d2 = SEG_LOWER;
      3'd7: d3 = SEG_LOWER;
    endcase
  end

  assign in0_o  = d0;
  assign in1_o  = d1;
  assign in2_o  = d2;
  assign in3_o  = d3;
  assign pos_o  = pos;
  assign step_o = step;

endmodule

// File: tb/tb_rotating_square_ctrl.sv
// Bench for rotating_square_ctrl: vector table, directed corners,
// random run against a position/prescaler reference model.
module tb_rotating_square_ctrl;

  localparam int DIV = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i  = 1'b0;
  logic       cw_i  = 1'b1;
  logic       clr_i = 1'b0;
  logic [6:0] in0_o, in1_o, in2_o, in3_o;
  logic [2:0] pos_o;
  logic       step_o;

  rotating_square_ctrl #(
    .TICK_DIV (DIV)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .cw_i   (cw_i),
    .clr_i  (clr_i),
    .in0_o  (in0_o),
    .in1_o  (in1_o),
    .in2_o  (in2_o),
    .in3_o  (in3_o),
    .pos_o  (pos_o),
    .step_o (step_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // reference model: enabled cycles into the current
  // position, position, and the step flag
  int m_cnt = 0;
  int m_pos = 0;
  int m_step = 0;

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic int exp_seg(input int p,
                                 input int d);
    if (p < 4)
      return (d == 3 - p) ? 'h1C : 'h7F;
    return (d == p - 4) ? 'h23 : 'h7F;
  endfunction

  function automatic int dig(input int d);
    case (d)
      0: return int'(in0_o);
      1: return int'(in1_o);
      2: return int'(in2_o);
      default: return int'(in3_o);
    endcase
  endfunction

  task automatic model(input logic r, e, c, k);
    if (r || k) begin
      m_cnt = 0; m_pos = 0; m_step = 0;
    end else if (e) begin
      m_cnt++;
      m_step = 0;
      if (m_cnt == DIV) begin
        m_cnt = 0;
        m_pos = (m_pos + (c ? 1 : 7)) % 8;
        m_step = 1;
      end
    end else begin
      m_step = 0;
    end
  endtask

  task automatic check_model();
    int lit;
    lit = 0;
    chk("pos", int'(pos_o), m_pos);
    chk("step", int'(step_o), m_step);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("in%0d", d), dig(d),
          exp_seg(m_pos, d));
      if (dig(d) != 'h7F) lit++;
    end
    chk("one_lit", lit, 1);
  endtask

  task automatic cycle(input logic r, e, c, k);
    rst_i = r; en_i = e; cw_i = c; clr_i = k;
    @(posedge clk_i);
    model(r, e, c, k);
    @(negedge clk_i);
    check_model();
  endtask

  task automatic run_to(input int p, input int c);
    int n;
    n = 0;
    while (!(m_pos == p && m_cnt == c) && n < 100) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      n++;
    end
    chk("run_to_reached", int'(n < 100), 1);
  endtask

  // number of enabled cycles until step_o shows
  task automatic wait_step(input logic c,
                           output int n);
    n = 0;
    do begin
      cycle(1'b0, 1'b1, c, 1'b0);
      n++;
    end while (step_o !== 1'b1 && n < 20);
  endtask

  typedef struct {
    logic rst, en, cw, clr;
    int   pos, step;
  } vec_t;

  vec_t vt[$];
  int n, steps;

  initial begin
    // reset, CCW from reset, clear, hold, CW
    vt = '{
      '{1,0,1,0, 0,0}, '{1,0,1,0, 0,0},
      '{1,0,1,0, 0,0}, '{0,1,0,0, 0,0},
      '{0,1,0,0, 0,0}, '{0,1,0,0, 0,0},
      '{0,1,0,0, 7,1}, '{0,1,0,0, 7,0},
      '{0,1,0,0, 7,0}, '{0,1,0,0, 7,0},
      '{0,1,0,0, 6,1}, '{0,1,1,1, 0,0},
      '{0,0,1,0, 0,0}, '{0,1,1,0, 0,0},
      '{0,1,1,0, 0,0}, '{0,1,1,0, 0,0},
      '{0,1,1,0, 1,1}, '{0,1,1,0, 1,0}
    };
    foreach (vt[i]) begin
      cycle(vt[i].rst, vt[i].en,
            vt[i].cw, vt[i].clr);
      chk($sformatf("vec%0d_pos", i),
          int'(pos_o), vt[i].pos);
      chk($sformatf("vec%0d_step", i),
          int'(step_o), vt[i].step);
    end

    // reset then 40 clockwise cycles
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_in3", int'(in3_o), 'h1C);
    chk("rst_in0", int'(in0_o), 'h7F);
    steps = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      if (step_o === 1'b1) steps++;
      if (i == 15) begin
        chk("cw_pos4", int'(pos_o), 4);
        chk("cw_pos4_in0", int'(in0_o), 'h23);
      end
    end
    chk("cw_steps", steps, 10);
    chk("cw_final_pos", int'(pos_o), 2);

    // freeze after 2 enabled cycles
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    steps = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      if (step_o === 1'b1) steps++;
    end
    chk("freeze_no_step", steps, 0);
    wait_step(1'b1, n);
    chk("freeze_resume", n, 2);

    // clear on the tick cycle at pos 3
    run_to(3, DIV - 1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_pos", int'(pos_o), 0);
    chk("clr_step", int'(step_o), 0);
    wait_step(1'b1, n);
    chk("clr_next_step", n, 4);

    // reset mid-run at pos 5, cnt 2
    run_to(5, 2);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("midrst_pos", int'(pos_o), 0);
    chk("midrst_in3", int'(in3_o), 'h1C);
    chk("midrst_step", int'(step_o), 0);

    // random run against the model
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 9) != 0),
            1'($urandom),
            ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
